// File: rtl/param_clk_measure_pkg.sv
// Shared types for clock-utility blocks: measurement FSM state encoding.
package param_clk_pkg;

  typedef enum logic [1:0] {
    PCM_IDLE,
    PCM_ARM,
    PCM_MEASURE,
    PCM_DONE
  } pcm_state_t;

endpackage

// File: rtl/param_clk_measure_if.sv
// Request/result handshake bundle for param_clk_measure; slave = the measuring block.
interface param_clk_measure_if #(
  parameter int cnt_width = 24
);

  logic                 clk_slow_in;
  logic                 start;
  logic                 busy;
  logic                 result_valid;
  logic                 result_ready;
  logic [cnt_width-1:0] result_div;
  logic                 result_timeout;
  logic                 result_ovf;

  modport master (
    output clk_slow_in, start, result_ready,
    input  busy, result_valid, result_div, result_timeout, result_ovf
  );

  modport slave (
    input  clk_slow_in, start, result_ready,
    output busy, result_valid, result_div, result_timeout, result_ovf
  );

endinterface

// File: rtl/param_clk_measure_sync_rise_det.sv
// 2-FF synchronizer for an asynchronous input followed by a one-cycle rising-edge pulse.
module sync_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic meta, sync, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_q <= sync;
    end
  end

  assign rise = sync & ~sync_q;

endmodule

// File: rtl/param_clk_measure.sv
// Measures clk cycles per period of a slow asynchronous signal, averaged over `periods`
// rising edges, with timeout abort and saturating accumulator.
module param_clk_measure
  import param_clk_pkg::*;
#(
  parameter int fast_hz        = 1000000,
  parameter int periods        = 4,
  parameter int cnt_width      = 24,
  parameter int timeout_cycles = fast_hz
) (
  input logic            clk,
  input logic            rst,
  param_clk_measure_if.slave bus
);

  localparam int TW = $clog2(timeout_cycles + 1);
  localparam int EW = $clog2(periods + 1);
  localparam int SH = $clog2(periods);
  localparam logic [cnt_width:0] ONE = (cnt_width + 1)'(1);

  pcm_state_t           state;
  logic [TW-1:0]        tmo_cnt;
  logic [EW-1:0]        edge_cnt;
  logic [cnt_width-1:0] total;
  logic                 rise;

  sync_rise_det u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.clk_slow_in),
    .rise     (rise)
  );

  // Next accumulator value; the carry marks saturation and drives the ovf flag.
  logic [cnt_width:0]   total_inc;
  logic [cnt_width-1:0] total_sat;
  logic [TW-1:0]        tmo_next;
  logic [EW-1:0]        edge_next;
  logic                 tmo_hit, edge_done, active, abort;

  assign total_inc = {1'b0, total} + ONE;
  assign total_sat = total_inc[cnt_width] ? '1 : total_inc[cnt_width-1:0];
  assign tmo_next  = tmo_cnt + TW'(1);
  assign tmo_hit   = (tmo_next == TW'(timeout_cycles));
  assign edge_next = edge_cnt + EW'(1);
  assign edge_done = (edge_next == EW'(periods));
  assign active    = (state == PCM_ARM) || (state == PCM_MEASURE);
  // An edge in the same cycle as the timeout wins.
  assign abort     = active && !rise && tmo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= PCM_IDLE;
      tmo_cnt            <= '0;
      edge_cnt           <= '0;
      total              <= '0;
      bus.busy           <= 1'b0;
      bus.result_valid   <= 1'b0;
      bus.result_div     <= '0;
      bus.result_timeout <= 1'b0;
      bus.result_ovf     <= 1'b0;
    end else if (abort) begin
      state              <= PCM_DONE;
      bus.busy           <= 1'b0;
      bus.result_valid   <= 1'b1;
      bus.result_div     <= '0;
      bus.result_timeout <= 1'b1;
      bus.result_ovf     <= 1'b0;
    end else begin
      case (state)
        PCM_IDLE: begin
          if (bus.start) begin
            state    <= PCM_ARM;
            tmo_cnt  <= '0;
            bus.busy <= 1'b1;
          end
        end
        PCM_ARM: begin
          if (rise) begin
            state    <= PCM_MEASURE;
            total    <= '0;
            edge_cnt <= '0;
            tmo_cnt  <= '0;
          end else begin
            tmo_cnt  <= tmo_next;
          end
        end
        PCM_MEASURE: begin
          total <= total_sat;
          if (rise) begin
            tmo_cnt  <= '0;
            edge_cnt <= edge_next;
            // The final edge cycle is counted, so N*P cycles yields exactly P.
            if (edge_done) begin
              state              <= PCM_DONE;
              bus.busy           <= 1'b0;
              bus.result_valid   <= 1'b1;
              bus.result_div     <= total_sat >> SH;
              bus.result_timeout <= 1'b0;
              bus.result_ovf     <= total_inc[cnt_width];
            end
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        PCM_DONE: begin
          if (bus.result_ready) begin
            state            <= PCM_IDLE;
            bus.result_valid <= 1'b0;
          end
        end
        default: state <= PCM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_clk_measure.sv
// Directed bench for param_clk_measure: averaging, timeout, hold-off, saturation, reset.
module tb_param_clk_measure;

  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic slow_en = 1'b0;
  int   hi_a = 5, lo_a = 5, hi_b = 5, lo_b = 5;

  param_clk_measure_if #(.cnt_width(CW)) bus ();

  param_clk_measure #(
    .fast_hz        (1000000),
    .periods        (4),
    .cnt_width      (CW),
    .timeout_cycles (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Slow signal: alternates period A (hi_a/lo_a) and period B (hi_b/lo_b) while enabled.
  initial begin
    bus.clk_slow_in = 1'b0;
    forever begin
      if (slow_en) begin
        bus.clk_slow_in = 1'b1; repeat (hi_a) @(negedge clk);
        bus.clk_slow_in = 1'b0; repeat (lo_a) @(negedge clk);
        bus.clk_slow_in = 1'b1; repeat (hi_b) @(negedge clk);
        bus.clk_slow_in = 1'b0; repeat (lo_b) @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output logic ok, output int cyc);
    cyc = 0;
    while (bus.result_valid !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    ok = (bus.result_valid === 1'b1);
  endtask

  task automatic accept(input string tag);
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.result_valid), 0);
    check({tag, "_busy_after"}, 32'(bus.busy), 0);
  endtask

  task automatic set_period(input int ha, input int la, input int hb, input int lb);
    hi_a = ha; lo_a = la; hi_b = hb; lo_b = lb;
    slow_en = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  initial begin
    logic ok;
    int   cyc;
    int   bad;
    bus.start = 1'b0;
    bus.result_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",    32'(bus.busy), 0);
    check("rst_valid",   32'(bus.result_valid), 0);
    check("rst_div",     32'(bus.result_div), 0);
    check("rst_timeout", 32'(bus.result_timeout), 0);
    check("rst_ovf",     32'(bus.result_ovf), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: steady period 10
    set_period(5, 5, 5, 5);
    pulse_start();
    check("t1_busy", 32'(bus.busy), 1);
    wait_valid(300, ok, cyc);
    check("t1_valid_seen", 32'(ok), 1);
    check("t1_div",     32'(bus.result_div), 10);
    check("t1_timeout", 32'(bus.result_timeout), 0);
    check("t1_ovf",     32'(bus.result_ovf), 0);
    check("t1_busy_done", 32'(bus.busy), 0);
    accept("t1");

    // 2: alternating 9 / 11
    set_period(4, 5, 5, 6);
    pulse_start();
    wait_valid(300, ok, cyc);
    check("t2_valid_seen", 32'(ok), 1);
    check("t2_div",     32'(bus.result_div), 10);
    check("t2_timeout", 32'(bus.result_timeout), 0);

    // 4: result held with ready low, start ignored
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) bus.start = 1'b1;
      if (i == 21) bus.start = 1'b0;
      @(negedge clk);
      if (bus.result_valid !== 1'b1 || bus.result_div !== CW'(10) || bus.busy !== 1'b0) bad++;
    end
    check("t4_hold_stable", 32'(bad), 0);
    bus.result_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    bus.start = 1'b0;
    check("t4_valid_drop", 32'(bus.result_valid), 0);
    check("t4_busy_accept", 32'(bus.busy), 0);
    repeat (5) @(negedge clk);
    check("t4_busy_later", 32'(bus.busy), 0);

    // 5: saturation, period 40 with 6-bit accumulator
    set_period(20, 20, 20, 20);
    pulse_start();
    wait_valid(500, ok, cyc);
    check("t5_valid_seen", 32'(ok), 1);
    check("t5_div",     32'(bus.result_div), 15);
    check("t5_ovf",     32'(bus.result_ovf), 1);
    check("t5_timeout", 32'(bus.result_timeout), 0);
    accept("t5");

    // 3: input held low -> timeout 100 cycles after ARM entry
    slow_en = 1'b0;
    repeat (100) @(negedge clk);
    pulse_start();
    check("t3_busy", 32'(bus.busy), 1);
    wait_valid(300, ok, cyc);
    check("t3_valid_seen", 32'(ok), 1);
    check("t3_latency", 32'(cyc), 100);
    check("t3_timeout", 32'(bus.result_timeout), 1);
    check("t3_div",     32'(bus.result_div), 0);
    check("t3_ovf",     32'(bus.result_ovf), 0);
    accept("t3");

    // 6: reset mid-measurement, then a clean measurement
    set_period(5, 5, 5, 5);
    pulse_start();
    repeat (25) @(negedge clk);
    check("t6_busy_pre", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("t6_busy_rst",  32'(bus.busy), 0);
    check("t6_valid_rst", 32'(bus.result_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    pulse_start();
    wait_valid(300, ok, cyc);
    check("t6_valid_seen", 32'(ok), 1);
    check("t6_div",     32'(bus.result_div), 10);
    check("t6_timeout", 32'(bus.result_timeout), 0);
    accept("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
